// File: rtl/mf_nco_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mf_nco_pkg
// Brief    : Shared types, defaults and helpers for the NCO clock-enable block.
// Revision : 1.0 - initial release
// ============================================================================
package mf_nco_pkg;

    localparam int c_NUM_CH_DEF   = 5;
    localparam int c_ACC_W_DEF    = 32;
    localparam int c_LOCK_CYC_DEF = 256;

    typedef enum logic [1:0] {
        UNCFG  = 2'd0,
        ALIGN  = 2'd1,
        SETTLE = 2'd2,
        LOCKED = 2'd3
    } nco_state_t;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mf_nco_channel.sv
`default_nettype none
// ============================================================================
// Module   : mf_nco_channel
// Brief    : One NCO channel: shadow inc/phase, active accumulator, wrap CE.
// Revision : 1.0 - initial release
// ============================================================================
module mf_nco_channel
    import mf_nco_pkg::*;
#(
    parameter int ACC_W = c_ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [ACC_W-1:0] i_inc,
    input  logic [ACC_W-1:0] i_phase,
    input  logic             i_load,
    output logic             o_ce,
    output logic             o_msb
);

    logic [ACC_W-1:0] r_sh_inc;
    logic [ACC_W-1:0] r_sh_phase;
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_acc;
    logic             r_ce;
    logic [ACC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_inc   <= '0;
            r_sh_phase <= '0;
            r_inc      <= '0;
            r_acc      <= '0;
            r_ce       <= 1'b0;
        end else begin
            if (i_wr) begin
                r_sh_inc   <= i_inc;
                r_sh_phase <= i_phase;
            end
            // Realign replaces the accumulate for this edge and suppresses any wrap.
            if (i_load) begin
                r_inc <= r_sh_inc;
                r_acc <= r_sh_phase;
                r_ce  <= 1'b0;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
                r_ce  <= w_sum[ACC_W];
            end
        end
    end

    assign o_ce  = r_ce;
    assign o_msb = r_acc[ACC_W-1];

endmodule
`default_nettype wire

// File: rtl/mf_nco_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : mf_nco_clkgen
// Brief    : Multi-channel fractional clock-enable generator with atomic realign.
// Revision : 1.0 - initial release
// ============================================================================
module mf_nco_clkgen
    import mf_nco_pkg::*;
#(
    parameter int NUM_CH   = c_NUM_CH_DEF,
    parameter int ACC_W    = c_ACC_W_DEF,
    parameter int LOCK_CYC = c_LOCK_CYC_DEF
) (
    input  logic                     refclk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [idx_w(NUM_CH)-1:0] cfg_ch,
    input  logic [ACC_W-1:0]         cfg_inc,
    input  logic [ACC_W-1:0]         cfg_phase,
    input  logic                     cfg_apply,
    output logic                     cfg_err,
    output logic [NUM_CH-1:0]        ce_out,
    output logic [NUM_CH-1:0]        clk_out,
    output logic                     locked
);

    localparam int              c_CH_W     = idx_w(NUM_CH);
    localparam int              c_CNT_W    = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
    localparam logic [c_CH_W:0] c_NUM_CH   = (c_CH_W + 1)'(NUM_CH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(LOCK_CYC - 1);

    nco_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;
    logic               r_locked;

    logic w_wr_acc;
    logic w_oor;
    logic w_load;

    assign cfg_ready = ~rst & (r_state != ALIGN);
    assign w_wr_acc  = cfg_valid & cfg_ready;
    assign w_oor     = ({1'b0, cfg_ch} >= c_NUM_CH);
    assign w_load    = (r_state == ALIGN);

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state  <= UNCFG;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_err <= w_wr_acc & w_oor;
            // ALIGN always lasts exactly one cycle, so an apply seen there is dropped.
            if (r_state == ALIGN) begin
                r_state  <= SETTLE;
                r_cnt    <= '0;
                r_locked <= 1'b0;
            end else if (cfg_apply) begin
                r_state  <= ALIGN;
                r_locked <= 1'b0;
            end else if (r_state == SETTLE) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_state  <= LOCKED;
                    r_locked <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    assign cfg_err = r_err;
    assign locked  = r_locked;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mf_nco_channel #(
            .ACC_W (ACC_W)
        ) u_ch (
            .clk     (refclk),
            .rst     (rst),
            .i_wr    (w_wr_acc & (cfg_ch == c_CH_W'(i))),
            .i_inc   (cfg_inc),
            .i_phase (cfg_phase),
            .i_load  (w_load),
            .o_ce    (ce_out[i]),
            .o_msb   (clk_out[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_mf_nco_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_mf_nco_clkgen
// Brief    : Self-checking bench: closed-form NCO model plus directed checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mf_nco_clkgen;

    localparam int     NUM_CH   = 3;
    localparam int     ACC_W    = 8;
    localparam int     LOCK_CYC = 16;
    localparam int     CH_W     = 2;
    localparam longint M        = 256;

    logic              refclk    = 1'b0;
    logic              rst       = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_apply = 1'b0;
    logic [CH_W-1:0]   cfg_ch    = '0;
    logic [ACC_W-1:0]  cfg_inc   = '0;
    logic [ACC_W-1:0]  cfg_phase = '0;
    logic              cfg_ready;
    logic              cfg_err;
    logic              locked;
    logic [NUM_CH-1:0] ce_out;
    logic [NUM_CH-1:0] clk_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Model: committed config per channel and the cycle its accumulator equals phase.
    longint sh_inc[NUM_CH];
    longint sh_ph[NUM_CH];
    longint a_inc[NUM_CH];
    longint a_ph[NUM_CH];
    longint a_st[NUM_CH];
    int     align_cyc = -1;
    int     lock_st   = -1;
    int     err_cyc   = -1;

    mf_nco_clkgen #(
        .NUM_CH   (NUM_CH),
        .ACC_W    (ACC_W),
        .LOCK_CYC (LOCK_CYC)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
        .cfg_apply (cfg_apply),
        .cfg_err   (cfg_err),
        .ce_out    (ce_out),
        .clk_out   (clk_out),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d want %0d", nm, cyc, act, exp);
        end
    endtask

    always @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_inc[i] = 0; sh_ph[i] = 0;
                a_inc[i]  = 0; a_ph[i]  = 0; a_st[i] = cyc + 1;
            end
            align_cyc = -1; lock_st = -1; err_cyc = -1;
        end else begin
            if (cfg_valid && cyc != align_cyc) begin
                if (int'(cfg_ch) < NUM_CH) begin
                    sh_inc[cfg_ch] = longint'(cfg_inc);
                    sh_ph[cfg_ch]  = longint'(cfg_phase);
                end else begin
                    err_cyc = cyc + 1;
                end
            end
            if (cyc == align_cyc) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    a_inc[i] = sh_inc[i]; a_ph[i] = sh_ph[i]; a_st[i] = cyc + 1;
                end
                lock_st = cyc + 1;
            end else if (cfg_apply) begin
                align_cyc = cyc + 1;
                lock_st   = -1;
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge refclk) begin
        longint k, v;
        if (chk_en) begin
            chk("ready", longint'(cfg_ready), longint'(!rst && cyc != align_cyc));
            chk("err", longint'(cfg_err), longint'(cyc == err_cyc));
            chk("locked", longint'(locked), longint'(lock_st >= 0 && cyc >= lock_st + LOCK_CYC));
            for (int i = 0; i < NUM_CH; i++) begin
                k = longint'(cyc) - a_st[i];
                v = a_ph[i] + a_inc[i] * k;
                chk($sformatf("clk_out[%0d]", i), longint'(clk_out[i]), longint'((v % M) >= M / 2));
                chk($sformatf("ce_out[%0d]", i), longint'(ce_out[i]),
                    longint'(k >= 1 && (v / M) != ((v - a_inc[i]) / M)));
            end
        end
    end

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic drive(input bit v, input int ch, input int inc, input int ph, input bit ap);
        cfg_valid = v;
        cfg_ch    = CH_W'(ch);
        cfg_inc   = ACC_W'(inc);
        cfg_phase = ACC_W'(ph);
        cfg_apply = ap;
        step();
        cfg_valid = 1'b0;
        cfg_apply = 1'b0;
    endtask

    task automatic wait_locked(input int t_ap, input string nm);
        for (int i = 0; i < 64 && !locked; i++) step();
        chk(nm, locked ? longint'(cyc - t_ap) : -1, 18);
    endtask

    initial begin
        int t, n, n_hi, last_ce1, first;
        step();
        chk_en = 1'b1;
        chk("rst_ready", longint'(cfg_ready), 0);
        step(); step();
        rst = 1'b0;
        #1;
        chk("ready_after_rst", longint'(cfg_ready), 1);
        chk("locked_after_rst", longint'(locked), 0);
        chk("clk_after_rst", longint'(clk_out), 0);

        // ch0 at quarter rate: CE every 4 cycles, 2 high / 2 low.
        drive(1, 0, 'h40, 'h00, 0);
        t = cyc;
        drive(0, 0, 0, 0, 1);
        chk("align_ready", longint'(cfg_ready), 0);
        wait_locked(t, "lock_latency");
        n = 0; n_hi = 0;
        for (int i = 0; i < 16; i++) begin
            n    += int'(ce_out[0]);
            n_hi += int'(clk_out[0]);
            step();
        end
        chk("ce0_per16", n, 4);
        chk("clk0_hi_per16", n_hi, 8);

        // Half-cycle phase offset on ch1: its CE leads ch0 by 2 cycles.
        drive(1, 0, 'h40, 'h00, 0);
        drive(1, 1, 'h40, 'h80, 0);
        drive(0, 0, 0, 0, 1);
        step();
        last_ce1 = -100;
        for (int i = 0; i < 24; i++) begin
            if (ce_out[1]) last_ce1 = cyc;
            if (ce_out[0]) chk("ch1_lead", cyc - last_ce1, 2);
            step();
        end

        // inc=3: exactly 3 CEs per 256 cycles for 4096 cycles; ch1 frozen high.
        drive(1, 0, 'h03, 'h00, 0);
        drive(1, 1, 'h00, 'h90, 0);
        drive(0, 0, 0, 0, 1);
        step();
        step();
        first = 0;
        for (int w = 0; w < 16; w++) begin
            n = 0;
            for (int i = 0; i < 256; i++) begin
                n     += int'(ce_out[0]);
                first += int'(ce_out[1]);
                step();
            end
            chk("ce0_per256", n, 3);
        end
        chk("frozen_ce1", first, 0);
        chk("frozen_clk1", longint'(clk_out[1]), 1);

        // Write forwarded into a same-cycle apply.
        drive(1, 1, 'h20, 'h00, 1);
        step();
        t = cyc;
        first = -1; n = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (ce_out[1]) begin
                n++;
                if (first < 0) first = cyc - t;
            end
        end
        chk("fwd_ce1_count", n, 2);
        chk("fwd_ce1_first", first, 8);

        // Out-of-range channel: single error pulse, no shadow touched.
        drive(1, 3, 'h55, 'h55, 0);
        chk("err_pulse", longint'(cfg_err), 1);
        step();
        chk("err_clear", longint'(cfg_err), 0);
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step();
        chk("oor_ch2_clk", longint'(clk_out[2]), 0);

        // Re-apply during SETTLE restarts the count; reset beats a held apply.
        drive(1, 0, 'h40, 'h00, 0);
        drive(1, 2, 'h10, 'h80, 0);
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step();
        t = cyc;
        drive(0, 0, 0, 0, 1);
        wait_locked(t, "relock_latency");
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        cfg_apply = 1'b1;
        step();
        rst = 1'b0;
        cfg_apply = 1'b0;
        #1;
        chk("rst_ce", longint'(ce_out), 0);
        chk("rst_clk", longint'(clk_out), 0);
        chk("rst_locked", longint'(locked), 0);
        chk("rst_beats_apply", longint'(cfg_ready), 1);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            n += int'(locked);
            step();
        end
        chk("no_lock_after_rst", n, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
